// File: rtl/writeback_queue_if.sv
// Purpose: handshake, register-file write port and forwarding-lookup signals of
//          the register write-back queue, bundled as one interface.
// Signals:
//   in_valid/in_ready/in_reg/in_data  write-back request handshake
//   drain_en                          register-file write port available
//   RegWrite/WriteRegister/WriteData  register-file write port (queue head)
//   lookup_reg1/2, lookup_hit1/2,
//   lookup_data1/2                    read-address forwarding
//   count                             occupied queue entries
// Modports: master = request/regfile side, slave = queue.
interface writeback_queue_if #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_reg;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  drain_en;
    logic                  RegWrite;
    logic [ADDR_WIDTH-1:0] WriteRegister;
    logic [DATA_WIDTH-1:0] WriteData;
    logic [ADDR_WIDTH-1:0] lookup_reg1;
    logic                  lookup_hit1;
    logic [DATA_WIDTH-1:0] lookup_data1;
    logic [ADDR_WIDTH-1:0] lookup_reg2;
    logic                  lookup_hit2;
    logic [DATA_WIDTH-1:0] lookup_data2;
    logic [CNT_W-1:0]      count;

    modport master (
        output in_valid, in_reg, in_data, drain_en, lookup_reg1, lookup_reg2,
        input  in_ready, RegWrite, WriteRegister, WriteData,
               lookup_hit1, lookup_data1, lookup_hit2, lookup_data2, count
    );

    modport slave (
        input  in_valid, in_reg, in_data, drain_en, lookup_reg1, lookup_reg2,
        output in_ready, RegWrite, WriteRegister, WriteData,
               lookup_hit1, lookup_data1, lookup_hit2, lookup_data2, count
    );
endinterface

// File: rtl/writeback_queue.sv
// Purpose: circular FIFO of pending register write-backs feeding the single
//          write port of the register file, with newest-value forwarding for
//          both register-file read addresses.
// Ports:
//   Clk    clock, rising edge
//   Rst_n  synchronous active-low reset; discards all pending writes
//   bus    writeback_queue_if.slave (request handshake, regfile write port,
//          two lookup ports, occupancy count)
// Optional feature: define WRITEBACK_QUEUE_COALESCE_EN to merge a request into
//   the youngest entry when it targets the same register (tail not popping).
module writeback_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                Clk,
    input  logic                Rst_n,
    writeback_queue_if.slave    bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] reg_q  [DEPTH];
    logic [ADDR_WIDTH-1:0] reg_d  [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;

    logic [PTR_W-1:0]      tail_ptr;
    logic                  not_empty;
    logic                  full;
    logic                  pop;
    logic                  coalesce;
    logic                  in_ready;
    logic                  accept;
    logic                  push;
    logic                  merge;

    assign not_empty = (count_q != '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign tail_ptr  = wr_ptr_q - PTR_W'(1);

    // Head goes to the regfile whenever the port is free; gated by reset so a
    // discarded entry can never be captured on the reset edge.
    assign pop = Rst_n & not_empty & bus.drain_en;

`ifdef WRITEBACK_QUEUE_COALESCE_EN
    // Merge only into a tail that survives this edge (not the sole popping entry).
    assign coalesce = not_empty
                    & (bus.in_reg != '0)
                    & (reg_q[tail_ptr] == bus.in_reg)
                    & ~(pop & (count_q == CNT_W'(1)));
`else
    assign coalesce = 1'b0;
`endif

    assign in_ready = ~full | pop | coalesce;
    assign accept   = bus.in_valid & in_ready;
    // $zero requests are consumed without occupying an entry.
    assign push     = accept & (bus.in_reg != '0) & ~coalesce;
    assign merge    = accept & coalesce;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        reg_d    = reg_q;
        data_d   = data_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (push) begin
            reg_d[wr_ptr_q]  = bus.in_reg;
            data_d[wr_ptr_q] = bus.in_data;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (merge) begin
            data_d[tail_ptr] = bus.in_data;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            reg_q    <= reg_d;
            data_q   <= data_d;
        end
    end

    // Scan oldest to youngest over occupied slots; the last match wins, so the
    // newest pending value is forwarded. The popping head still counts.
    function automatic logic [DATA_WIDTH:0] lookup(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH:0] res;
        logic [PTR_W-1:0]    idx;
        res = '0;
        idx = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (addr != '0) && (reg_q[idx] == addr)) begin
                res = {1'b1, data_q[idx]};
            end
        end
        return res;
    endfunction

    logic [DATA_WIDTH:0] look1;
    logic [DATA_WIDTH:0] look2;

    always_comb begin
        look1 = lookup(bus.lookup_reg1);
        look2 = lookup(bus.lookup_reg2);
    end

    assign bus.lookup_hit1   = look1[DATA_WIDTH];
    assign bus.lookup_data1  = look1[DATA_WIDTH-1:0];
    assign bus.lookup_hit2   = look2[DATA_WIDTH];
    assign bus.lookup_data2  = look2[DATA_WIDTH-1:0];

    assign bus.in_ready      = in_ready;
    assign bus.RegWrite      = pop;
    assign bus.WriteRegister = reg_q[rd_ptr_q];
    assign bus.WriteData     = data_q[rd_ptr_q];
    assign bus.count         = count_q;
endmodule
